// File: rtl/tx_serialiser_pkg.sv
// tx_serialiser_pkg: shared Tx constants, serialiser state type and parity helper
package tx_serialiser_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } tx_ser_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/tx_interface.sv
// tx_interface: Tx stream bundle, byte-wide (BY_BYTE=1) or bit-wide (BY_BYTE=0), with protocol checks
interface tx_interface #(
    parameter bit BY_BYTE = 1'b1
) (
    input logic clk,
    input logic rst_n
);
    localparam int W = BY_BYTE ? 8 : 1;

    logic [W-1:0] data;
    logic         data_valid;
    logic [2:0]   data_bits;
    logic         last_bit_in_byte;
    logic         req;

    a_req_pulse: assert property (@(posedge clk) disable iff (!rst_n) req |=> !req);

    if (BY_BYTE) begin : g_byte
        a_known: assert property (@(posedge clk) disable iff (!rst_n)
            data_valid |-> !$isunknown({data, data_bits}));
    end else begin : g_bit
        a_last: assert property (@(posedge clk) disable iff (!rst_n)
            last_bit_in_byte |-> data_valid);
    end

endinterface

// File: rtl/tx_serialiser.sv
// tx_serialiser: byte stream to LSB-first bit stream with optional odd parity after full bytes
module tx_serialiser
    import tx_serialiser_pkg::*;
#(
    parameter bit ADD_PARITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_data_valid,
    input  logic [2:0] in_data_bits,
    output logic       in_req,
    output logic       out_data,
    output logic       out_data_valid,
    output logic       out_last_bit_in_byte,
    input  logic       out_req
);

    tx_ser_state_t state, state_nx;
    logic [7:0] sr, sr_nx;
    logic [3:0] cnt, cnt_nx, nb;
    logic full, full_nx, par, par_nx;
    logic req_nx, dat_nx, val_nx, last_nx;
    logic final_bit, to_par, shift, boundary, load, stop;

    // decode the events that move a byte through the serialiser
    always_comb begin
        nb        = (in_data_bits == 3'd0) ? 4'(BITS_PER_BYTE) : {1'b0, in_data_bits};
        final_bit = (state == DATA) && (cnt == 4'd1);
        to_par    = out_req && final_bit && full && ADD_PARITY;
        shift     = out_req && (state == DATA) && !final_bit;
        boundary  = out_req && ((final_bit && !(full && ADD_PARITY)) || (state == PARITY));
        load      = in_data_valid && ((state == IDLE) || boundary);
        stop      = boundary && !in_data_valid;
    end

    // next state: load enters DATA, a consumed full byte enters PARITY, an empty boundary idles
    always_comb begin
        state_nx = load ? DATA : to_par ? PARITY : stop ? IDLE : state;
    end

    // next datapath and registered output values
    always_comb begin
        sr_nx   = load ? in_data : shift ? {1'b0, sr[7:1]} : sr;
        cnt_nx  = load ? nb : shift ? cnt - 4'd1 : cnt;
        full_nx = load ? (in_data_bits == 3'd0) : full;
        par_nx  = load ? odd_parity(in_data) : par;
        req_nx  = load;
        dat_nx  = load ? in_data[0] : shift ? sr[1] : to_par ? par : stop ? 1'b0 : out_data;
        val_nx  = load ? 1'b1 : stop ? 1'b0 : out_data_valid;
        last_nx = load ? (in_data_bits == 3'd1) :
                  shift ? ((cnt == 4'd2) && !(full && ADD_PARITY)) :
                  to_par ? 1'b1 : stop ? 1'b0 : out_last_bit_in_byte;
    end

    // state register with datapath and outputs; reset drops any byte in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            sr                   <= 8'd0;
            cnt                  <= 4'd0;
            full                 <= 1'b0;
            par                  <= 1'b0;
            in_req               <= 1'b0;
            out_data             <= 1'b0;
            out_data_valid       <= 1'b0;
            out_last_bit_in_byte <= 1'b0;
        end else begin
            state                <= state_nx;
            sr                   <= sr_nx;
            cnt                  <= cnt_nx;
            full                 <= full_nx;
            par                  <= par_nx;
            in_req               <= req_nx;
            out_data             <= dat_nx;
            out_data_valid       <= val_nx;
            out_last_bit_in_byte <= last_nx;
        end
    end

endmodule

// File: tb/tb_tx_serialiser.sv
// tb_tx_serialiser: directed checks of the byte-to-bit serialiser with and without parity
module tb_tx_serialiser;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    int reqs = 0;
    int nreqs = 0;

    always #5 clk = ~clk;
    assign rst_n = ~rst;

    tx_interface #(.BY_BYTE(1'b1)) bi (.clk(clk), .rst_n(rst_n));
    tx_interface #(.BY_BYTE(1'b0)) bo (.clk(clk), .rst_n(rst_n));
    tx_interface #(.BY_BYTE(1'b1)) ni (.clk(clk), .rst_n(rst_n));
    tx_interface #(.BY_BYTE(1'b0)) no (.clk(clk), .rst_n(rst_n));

    tx_serialiser #(.ADD_PARITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_data(bi.data), .in_data_valid(bi.data_valid), .in_data_bits(bi.data_bits), .in_req(bi.req),
        .out_data(bo.data), .out_data_valid(bo.data_valid),
        .out_last_bit_in_byte(bo.last_bit_in_byte), .out_req(bo.req)
    );

    tx_serialiser #(.ADD_PARITY(1'b0)) dut_np (
        .clk(clk), .rst(rst),
        .in_data(ni.data), .in_data_valid(ni.data_valid), .in_data_bits(ni.data_bits), .in_req(ni.req),
        .out_data(no.data), .out_data_valid(no.data_valid),
        .out_last_bit_in_byte(no.last_bit_in_byte), .out_req(no.req)
    );

    // count in_req pulses of each instance, sampled away from the active edge
    always @(negedge clk) begin
        if (bi.req === 1'b1) reqs <= reqs + 1;
        if (ni.req === 1'b1) nreqs <= nreqs + 1;
    end

    // pulse out_req for one tick from a falling edge, returning the bit shown before it and state one tick after
    task automatic take(input bit np, output logic d, output logic l, output logic v, output logic va, output logic rq);
        d = np ? no.data[0] : bo.data[0];
        l = np ? no.last_bit_in_byte : bo.last_bit_in_byte;
        v = np ? no.data_valid : bo.data_valid;
        if (np) no.req = 1'b1; else bo.req = 1'b1;
        @(negedge clk);
        no.req = 1'b0;
        bo.req = 1'b0;
        va = np ? no.data_valid : bo.data_valid;
        rq = np ? ni.req : bi.req;
    endtask

    task automatic gap();
        repeat (7) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bi.req !== 1'b0) begin failures++; $display("FAIL reset in_req got %b want 0", bi.req); end
        if (bo.data !== 1'b0) begin failures++; $display("FAIL reset out_data got %b want 0", bo.data); end
        if (bo.data_valid !== 1'b0) begin failures++; $display("FAIL reset out_data_valid got %b want 0", bo.data_valid); end
        if (bo.last_bit_in_byte !== 1'b0) begin failures++; $display("FAIL reset out_last got %b want 0", bo.last_bit_in_byte); end
        if (no.data_valid !== 1'b0) begin failures++; $display("FAIL reset np out_data_valid got %b want 0", no.data_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [8:0] exp;
        logic d, l, v, va, rq;
        int r0;
        exp = 9'b1_1010_0101;
        r0 = reqs;
        bi.data = 8'hA5; bi.data_bits = 3'd0; bi.data_valid = 1'b1;
        @(negedge clk);
        checks += 3;
        if (bi.req !== 1'b1) begin failures++; $display("FAIL single start in_req got %b want 1", bi.req); end
        if (bo.data_valid !== 1'b1) begin failures++; $display("FAIL single start valid got %b want 1", bo.data_valid); end
        if (bo.data !== 1'b1) begin failures++; $display("FAIL single start bit0 got %b want 1", bo.data); end
        bi.data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bi.req !== 1'b0) begin failures++; $display("FAIL single in_req width got %b want 0", bi.req); end
        for (int i = 0; i < 9; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks += 3;
            if (d !== exp[i]) begin failures++; $display("FAIL single bit%0d got %b want %b", i, d, exp[i]); end
            if (l !== (i == 8)) begin failures++; $display("FAIL single last%0d got %b want %b", i, l, i == 8); end
            if (va !== (i < 8)) begin failures++; $display("FAIL single valid_after%0d got %b want %b", i, va, i < 8); end
            gap();
        end
        checks++;
        if (reqs - r0 != 1) begin failures++; $display("FAIL single in_req count got %0d want 1", reqs - r0); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic d, l, v, va, rq;
        int r0;
        exp = 18'b0_1000_0000_0_0000_0001;
        r0 = reqs;
        bi.data = 8'h01; bi.data_bits = 3'd0; bi.data_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bi.req !== 1'b1) begin failures++; $display("FAIL b2b first in_req got %b want 1", bi.req); end
        bi.data = 8'h80;
        for (int i = 0; i < 18; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks += 5;
            if (d !== exp[i]) begin failures++; $display("FAIL b2b bit%0d got %b want %b", i, d, exp[i]); end
            if (l !== (i == 8 || i == 17)) begin failures++; $display("FAIL b2b last%0d got %b want %b", i, l, i == 8 || i == 17); end
            if (v !== 1'b1) begin failures++; $display("FAIL b2b valid%0d got %b want 1", i, v); end
            if (va !== (i != 17)) begin failures++; $display("FAIL b2b valid_after%0d got %b want %b", i, va, i != 17); end
            if (rq !== (i == 8)) begin failures++; $display("FAIL b2b in_req%0d got %b want %b", i, rq, i == 8); end
            if (i == 8) bi.data_valid = 1'b0;
            gap();
        end
        checks++;
        if (reqs - r0 != 2) begin failures++; $display("FAIL b2b in_req count got %0d want 2", reqs - r0); end
    endtask

    task automatic test_partial();
        logic [2:0] exp;
        logic d, l, v, va, rq;
        int r0;
        exp = 3'b101;
        r0 = reqs;
        bi.data = 8'h05; bi.data_bits = 3'd3; bi.data_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bi.req !== 1'b1) begin failures++; $display("FAIL partial in_req got %b want 1", bi.req); end
        bi.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks += 3;
            if (d !== exp[i]) begin failures++; $display("FAIL partial bit%0d got %b want %b", i, d, exp[i]); end
            if (l !== (i == 2)) begin failures++; $display("FAIL partial last%0d got %b want %b", i, l, i == 2); end
            if (va !== (i < 2)) begin failures++; $display("FAIL partial valid_after%0d got %b want %b", i, va, i < 2); end
            gap();
        end
        checks += 3;
        if (bo.data_valid !== 1'b0) begin failures++; $display("FAIL partial idle valid got %b want 0", bo.data_valid); end
        if (bo.last_bit_in_byte !== 1'b0) begin failures++; $display("FAIL partial idle last got %b want 0", bo.last_bit_in_byte); end
        if (reqs - r0 != 1) begin failures++; $display("FAIL partial in_req count got %0d want 1", reqs - r0); end
        bi.data_bits = 3'd0;
    endtask

    task automatic test_no_parity();
        logic d, l, v, va, rq;
        int r0;
        r0 = nreqs;
        ni.data = 8'hFF; ni.data_bits = 3'd0; ni.data_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ni.req !== 1'b1) begin failures++; $display("FAIL nopar in_req got %b want 1", ni.req); end
        ni.data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            take(1'b1, d, l, v, va, rq);
            checks += 3;
            if (d !== 1'b1) begin failures++; $display("FAIL nopar bit%0d got %b want 1", i, d); end
            if (l !== (i == 7)) begin failures++; $display("FAIL nopar last%0d got %b want %b", i, l, i == 7); end
            if (va !== (i < 7)) begin failures++; $display("FAIL nopar valid_after%0d got %b want %b", i, va, i < 7); end
            gap();
        end
        checks += 2;
        if (no.data_valid !== 1'b0) begin failures++; $display("FAIL nopar ninth bit valid got %b want 0", no.data_valid); end
        if (nreqs - r0 != 1) begin failures++; $display("FAIL nopar in_req count got %0d want 1", nreqs - r0); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        logic d, l, v, va, rq;
        bi.data = 8'h3C; bi.data_bits = 3'd0; bi.data_valid = 1'b1;
        @(negedge clk);
        bi.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks++;
            if (d !== (i == 2)) begin failures++; $display("FAIL rstmid pre bit%0d got %b want %b", i, d, i == 2); end
            gap();
        end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (bo.data_valid !== 1'b0) begin failures++; $display("FAIL rstmid async valid got %b want 0", bo.data_valid); end
        if (bo.data !== 1'b0) begin failures++; $display("FAIL rstmid async data got %b want 0", bo.data); end
        if (bo.last_bit_in_byte !== 1'b0) begin failures++; $display("FAIL rstmid async last got %b want 0", bo.last_bit_in_byte); end
        if (bi.req !== 1'b0) begin failures++; $display("FAIL rstmid async in_req got %b want 0", bi.req); end
        @(negedge clk);
        rst = 1'b0;
        exp = 9'b1_0001_0010;
        bi.data = 8'h12; bi.data_valid = 1'b1;
        @(negedge clk);
        bi.data_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks += 3;
            if (d !== exp[i]) begin failures++; $display("FAIL rstmid bit%0d got %b want %b", i, d, exp[i]); end
            if (l !== (i == 8)) begin failures++; $display("FAIL rstmid last%0d got %b want %b", i, l, i == 8); end
            if (va !== (i < 8)) begin failures++; $display("FAIL rstmid valid_after%0d got %b want %b", i, va, i < 8); end
            gap();
        end
    endtask

    task automatic test_idle_and_drop();
        logic [8:0] exp;
        logic d, l, v, va, rq;
        int r0;
        for (int k = 0; k < 3; k++) begin
            bo.req = 1'b1;
            @(negedge clk);
            bo.req = 1'b0;
            checks += 4;
            if (bo.data_valid !== 1'b0) begin failures++; $display("FAIL idle%0d valid got %b want 0", k, bo.data_valid); end
            if (bo.data !== 1'b0) begin failures++; $display("FAIL idle%0d data got %b want 0", k, bo.data); end
            if (bo.last_bit_in_byte !== 1'b0) begin failures++; $display("FAIL idle%0d last got %b want 0", k, bo.last_bit_in_byte); end
            if (bi.req !== 1'b0) begin failures++; $display("FAIL idle%0d in_req got %b want 0", k, bi.req); end
            gap();
        end
        exp = 9'b1_1100_0011;
        r0 = reqs;
        bi.data = 8'hC3; bi.data_bits = 3'd0; bi.data_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            take(1'b0, d, l, v, va, rq);
            checks += 3;
            if (d !== exp[i]) begin failures++; $display("FAIL drop bit%0d got %b want %b", i, d, exp[i]); end
            if (l !== (i == 8)) begin failures++; $display("FAIL drop last%0d got %b want %b", i, l, i == 8); end
            if (va !== (i < 8)) begin failures++; $display("FAIL drop valid_after%0d got %b want %b", i, va, i < 8); end
            if (i == 3) bi.data_valid = 1'b0;
            gap();
        end
        checks++;
        if (reqs - r0 != 1) begin failures++; $display("FAIL drop in_req count got %0d want 1", reqs - r0); end
    endtask

    initial begin
        bi.data = 8'h00; bi.data_valid = 1'b0; bi.data_bits = 3'd0; bi.last_bit_in_byte = 1'b0;
        ni.data = 8'h00; ni.data_valid = 1'b0; ni.data_bits = 3'd0; ni.last_bit_in_byte = 1'b0;
        bo.req = 1'b0; bo.data_bits = 3'd0;
        no.req = 1'b0; no.data_bits = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_partial();
        test_no_parity();
        test_reset_mid();
        test_idle_and_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
